// File: rtl/multi_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// multi_cycle_ctrl
// Main control FSM for a multi-cycle 32-bit CPU. Sequences fetch, decode,
// execute, memory and writeback over a shared datapath (one ALU, one memory
// port, IR, register file, PC) and drives every datapath strobe, mux select
// and the ALU function code. Memory waits are bounded by a timeout.
//
// Parameters:
//   TIMEOUT_CYC  cycles a memory state waits for mem_ready before abort
//                (1 .. 2**CNT_W-1)
//   CNT_W        width of the memory wait counter
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   opcode, funct          IR[31:26], IR[5:0]
//   zero                   ALU zero flag (consumed by the datapath PC gate)
//   mem_ready              memory completes the current access this cycle
//   pc_write/_cond         unconditional / zero-qualified PC load
//   iord                   memory address select: 0=PC, 1=ALUOut
//   mem_read, mem_write    memory requests
//   ir_write               IR load
//   mem_to_reg, reg_dst    register-file write data / destination selects
//   reg_write              register-file write
//   alu_src_a, alu_src_b   ALU operand selects
//   ext_zero               zero-extend the immediate (ori)
//   pc_source              PC source select: 0=ALU, 1=ALUOut, 2=jump target
//   alu_ctrl               ALU function code
//   illegal, mem_err       one-cycle pulses: unsupported inst, memory timeout
//   inst_cnt               retired-instruction count
//
// Optional feature macro: MULTI_CYCLE_CTRL_INST_CNT_EN
//   defined   -> inst_cnt is a free-running 32-bit retired-instruction count
//   undefined -> inst_cnt is tied to 0 and no counter flops exist
//
// Outputs are decoded combinationally from the state (plus opcode, funct and
// mem_ready where the handshake needs it) and forced to their idle values
// while rst_n is low, so an asynchronous reset silences the datapath at once.
// -----------------------------------------------------------------------------
module multi_cycle_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter int unsigned CNT_W       = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic        iord,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        mem_to_reg,
   output logic        reg_dst,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic        ext_zero,
   output logic [1:0]  pc_source,
   output logic [2:0]  alu_ctrl,
   output logic        illegal,
   output logic        mem_err,
   output logic [31:0] inst_cnt
);

   localparam int unsigned OP_W   = 6;
   localparam int unsigned ALU_W  = 3;
   localparam int unsigned SEL_W  = 2;
   localparam int unsigned INST_W = 32;

   // Opcodes
   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

   // R-type function codes
   localparam logic [OP_W-1:0] FN_ADD = 6'h20;
   localparam logic [OP_W-1:0] FN_SUB = 6'h22;
   localparam logic [OP_W-1:0] FN_AND = 6'h24;
   localparam logic [OP_W-1:0] FN_OR  = 6'h25;
   localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

   // ALU function codes
   localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
   localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
   localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
   localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
   localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

   // ALU operand B selects
   localparam logic [SEL_W-1:0] SRC_B_REG    = 2'd0;
   localparam logic [SEL_W-1:0] SRC_B_FOUR   = 2'd1;
   localparam logic [SEL_W-1:0] SRC_B_IMM    = 2'd2;
   localparam logic [SEL_W-1:0] SRC_B_IMM_SH = 2'd3;

   // PC source selects
   localparam logic [SEL_W-1:0] PCS_ALU    = 2'd0;
   localparam logic [SEL_W-1:0] PCS_ALUOUT = 2'd1;
   localparam logic [SEL_W-1:0] PCS_JUMP   = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

   typedef enum logic [3:0] {
      ST_FETCH   = 4'd0,
      ST_DECODE  = 4'd1,
      ST_MEM_ADR = 4'd2,
      ST_MEM_RD  = 4'd3,
      ST_MEM_WB  = 4'd4,
      ST_MEM_WR  = 4'd5,
      ST_EXEC_R  = 4'd6,
      ST_R_WB    = 4'd7,
      ST_EXEC_I  = 4'd8,
      ST_I_WB    = 4'd9,
      ST_BRANCH  = 4'd10,
      ST_JUMP    = 4'd11
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

   logic               wait_st_c;
   logic               timeout_c;
   logic               funct_ok_c;
   logic [ALU_W-1:0]   r_alu_c;
   logic               is_ori_c;
   logic [ALU_W-1:0]   i_alu_c;
   logic               retire_c;

   logic               pc_write_c;
   logic               pc_write_cond_c;
   logic               iord_c;
   logic               mem_read_c;
   logic               mem_write_c;
   logic               ir_write_c;
   logic               mem_to_reg_c;
   logic               reg_dst_c;
   logic               reg_write_c;
   logic               alu_src_a_c;
   logic [SEL_W-1:0]   alu_src_b_c;
   logic               ext_zero_c;
   logic [SEL_W-1:0]   pc_source_c;
   logic [ALU_W-1:0]   alu_ctrl_c;
   logic               illegal_c;
   logic               mem_err_c;

   // The branch decision is made by the datapath from pc_write_cond and zero.
   logic               unused_zero;
   assign unused_zero = zero;

   // A memory wait expires when the counter hits the limit with no ready.
   assign wait_st_c = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) ||
                      (state_q == ST_MEM_WR);
   assign timeout_c = wait_st_c && !mem_ready && (wait_cnt_q == CNT_LIMIT);

   assign is_ori_c = (opcode == OP_ORI);
   assign i_alu_c  = is_ori_c ? ALU_OR : ALU_ADD;

   // R-type function decode, shared by DECODE (legality) and EXEC_R/R_WB.
   always_comb begin : funct_dec
      funct_ok_c = 1'b1;
      r_alu_c    = ALU_ADD;
      case (funct)
         FN_ADD:  r_alu_c = ALU_ADD;
         FN_SUB:  r_alu_c = ALU_SUB;
         FN_AND:  r_alu_c = ALU_AND;
         FN_OR:   r_alu_c = ALU_OR;
         FN_SLT:  r_alu_c = ALU_SLT;
         default: funct_ok_c = 1'b0;
      endcase
   end

   // Next state and per-state datapath controls.
   always_comb begin : fsm_next
      state_d         = state_q;
      pc_write_c      = 1'b0;
      pc_write_cond_c = 1'b0;
      iord_c          = 1'b0;
      mem_read_c      = 1'b0;
      mem_write_c     = 1'b0;
      ir_write_c      = 1'b0;
      mem_to_reg_c    = 1'b0;
      reg_dst_c       = 1'b0;
      reg_write_c     = 1'b0;
      alu_src_a_c     = 1'b0;
      alu_src_b_c     = SRC_B_REG;
      ext_zero_c      = 1'b0;
      pc_source_c     = PCS_ALU;
      alu_ctrl_c      = ALU_ADD;
      illegal_c       = 1'b0;
      mem_err_c       = 1'b0;
      retire_c        = 1'b0;

      case (state_q)
         ST_FETCH: begin
            // PC + 4 computed while the instruction read is outstanding.
            mem_read_c  = !timeout_c;
            alu_src_b_c = SRC_B_FOUR;
            pc_source_c = PCS_ALU;
            if (mem_ready) begin
               ir_write_c = 1'b1;
               pc_write_c = 1'b1;
               state_d    = ST_DECODE;
            end else if (timeout_c) begin
               mem_err_c = 1'b1;
               state_d   = ST_FETCH;
            end
         end

         ST_DECODE: begin
            // Branch target speculatively into ALUOut.
            alu_src_b_c = SRC_B_IMM_SH;
            case (opcode)
               OP_RTYPE: begin
                  if (funct_ok_c) begin
                     state_d = ST_EXEC_R;
                  end else begin
                     illegal_c = 1'b1;
                     state_d   = ST_FETCH;
                  end
               end
               OP_LW, OP_SW:     state_d = ST_MEM_ADR;
               OP_ADDI, OP_ORI:  state_d = ST_EXEC_I;
               OP_BEQ:           state_d = ST_BRANCH;
               OP_J:             state_d = ST_JUMP;
               default: begin
                  illegal_c = 1'b1;
                  state_d   = ST_FETCH;
               end
            endcase
         end

         ST_MEM_ADR: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = SRC_B_IMM;
            state_d     = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
         end

         ST_MEM_RD: begin
            mem_read_c = !timeout_c;
            iord_c     = 1'b1;
            if (mem_ready) begin
               state_d = ST_MEM_WB;
            end else if (timeout_c) begin
               mem_err_c = 1'b1;
               state_d   = ST_FETCH;
            end
         end

         ST_MEM_WB: begin
            reg_write_c  = 1'b1;
            mem_to_reg_c = 1'b1;
            retire_c     = 1'b1;
            state_d      = ST_FETCH;
         end

         ST_MEM_WR: begin
            mem_write_c = !timeout_c;
            iord_c      = 1'b1;
            if (mem_ready) begin
               retire_c = 1'b1;
               state_d  = ST_FETCH;
            end else if (timeout_c) begin
               mem_err_c = 1'b1;
               state_d   = ST_FETCH;
            end
         end

         ST_EXEC_R: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = SRC_B_REG;
            alu_ctrl_c  = r_alu_c;
            state_d     = ST_R_WB;
         end

         ST_R_WB: begin
            reg_write_c = 1'b1;
            reg_dst_c   = 1'b1;
            alu_ctrl_c  = r_alu_c;
            retire_c    = 1'b1;
            state_d     = ST_FETCH;
         end

         ST_EXEC_I: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = SRC_B_IMM;
            ext_zero_c  = is_ori_c;
            alu_ctrl_c  = i_alu_c;
            state_d     = ST_I_WB;
         end

         ST_I_WB: begin
            reg_write_c = 1'b1;
            alu_ctrl_c  = i_alu_c;
            retire_c    = 1'b1;
            state_d     = ST_FETCH;
         end

         ST_BRANCH: begin
            // Compare A - B; the datapath qualifies the PC load with zero.
            alu_src_a_c     = 1'b1;
            alu_src_b_c     = SRC_B_REG;
            alu_ctrl_c      = ALU_SUB;
            pc_write_cond_c = 1'b1;
            pc_source_c     = PCS_ALUOUT;
            retire_c        = 1'b1;
            state_d         = ST_FETCH;
         end

         ST_JUMP: begin
            pc_write_c  = 1'b1;
            pc_source_c = PCS_JUMP;
            retire_c    = 1'b1;
            state_d     = ST_FETCH;
         end

         default: state_d = ST_FETCH;
      endcase
   end

   // Wait counter: zero outside wait states, so every wait state is entered
   // with a cleared count; counts only cycles without ready.
   always_comb begin : wait_cnt_next
      wait_cnt_d = '0;
      if (wait_st_c && !mem_ready && !timeout_c) begin
         wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
   end

   // State and wait counter registers.
   always_ff @(posedge clk or negedge rst_n) begin : fsm_regs
      if (!rst_n) begin
         state_q    <= ST_FETCH;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Outputs held idle while reset is asserted.
   assign pc_write      = rst_n & pc_write_c;
   assign pc_write_cond = rst_n & pc_write_cond_c;
   assign iord          = rst_n & iord_c;
   assign mem_read      = rst_n & mem_read_c;
   assign mem_write     = rst_n & mem_write_c;
   assign ir_write      = rst_n & ir_write_c;
   assign mem_to_reg    = rst_n & mem_to_reg_c;
   assign reg_dst       = rst_n & reg_dst_c;
   assign reg_write     = rst_n & reg_write_c;
   assign alu_src_a     = rst_n & alu_src_a_c;
   assign alu_src_b     = rst_n ? alu_src_b_c : SRC_B_REG;
   assign ext_zero      = rst_n & ext_zero_c;
   assign pc_source     = rst_n ? pc_source_c : PCS_ALU;
   assign alu_ctrl      = rst_n ? alu_ctrl_c : ALU_ADD;
   assign illegal       = rst_n & illegal_c;
   assign mem_err       = rst_n & mem_err_c;

`ifdef MULTI_CYCLE_CTRL_INST_CNT_EN
   // Retired-instruction counter; aborted instructions never retire.
   logic [INST_W-1:0] inst_cnt_q, inst_cnt_d;

   always_comb begin : inst_cnt_next
      inst_cnt_d = inst_cnt_q;
      if (retire_c) begin
         inst_cnt_d = inst_cnt_q + INST_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin : inst_cnt_reg
      if (!rst_n) begin
         inst_cnt_q <= '0;
      end else begin
         inst_cnt_q <= inst_cnt_d;
      end
   end

   assign inst_cnt = inst_cnt_q;
`else
   logic unused_retire;
   assign unused_retire = retire_c;
   assign inst_cnt      = INST_W'(0);
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multi_cycle_ctrl
// Scripted bench for multi_cycle_ctrl (TIMEOUT_CYC=4). Each scenario lists the
// per-cycle inputs with the output vector expected in that cycle; expected
// vectors enter a scoreboard queue as the cycle is driven and are popped and
// compared at the falling edge.
// -----------------------------------------------------------------------------
module tb_multi_cycle_ctrl;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [5:0] OP_R   = 6'h00;
   localparam logic [5:0] OP_J   = 6'h02;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_ADDI= 6'h08;
   localparam logic [5:0] OP_ORI = 6'h0D;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2B;
   localparam logic [5:0] OP_BAD = 6'h3F;

`ifdef MULTI_CYCLE_CTRL_INST_CNT_EN
   localparam int unsigned INC = 1;
`else
   localparam int unsigned INC = 0;
`endif

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       ext_zero;
      logic [1:0] pc_source;
      logic [2:0] alu_ctrl;
      logic       illegal;
      logic       mem_err;
   } out_t;

   typedef struct {
      logic [5:0] opc;
      logic [5:0] fn;
      logic       z;
      logic       rdy;
      out_t       exp;
      bit         ret;
   } cyc_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  opcode, funct;
   logic        zero, mem_ready;
   logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic        mem_to_reg, reg_dst, reg_write, alu_src_a, ext_zero;
   logic [1:0]  alu_src_b, pc_source;
   logic [2:0]  alu_ctrl;
   logic        illegal, mem_err;
   logic [31:0] inst_cnt;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_inst = 32'd0;
   out_t        sb_q[$];

   always #5 clk = ~clk;

   multi_cycle_ctrl #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
      .pc_source(pc_source), .alu_ctrl(alu_ctrl), .illegal(illegal),
      .mem_err(mem_err), .inst_cnt(inst_cnt)
   );

   // Expected output vectors per FSM state.
   function automatic out_t o_base();
      out_t o;
      o = '0;
      o.alu_ctrl = ALU_ADD;
      return o;
   endfunction

   function automatic out_t o_fetch(input logic rdy, input logic tmo);
      out_t o;
      o = o_base();
      o.mem_read  = ~tmo;
      o.alu_src_b = 2'd1;
      o.ir_write  = rdy;
      o.pc_write  = rdy;
      o.mem_err   = tmo;
      return o;
   endfunction

   function automatic out_t o_decode(input logic ill);
      out_t o;
      o = o_base();
      o.alu_src_b = 2'd3;
      o.illegal   = ill;
      return o;
   endfunction

   function automatic out_t o_exec_r(input logic [2:0] alu);
      out_t o;
      o = o_base();
      o.alu_src_a = 1'b1;
      o.alu_ctrl  = alu;
      return o;
   endfunction

   function automatic out_t o_rwb(input logic [2:0] alu);
      out_t o;
      o = o_base();
      o.reg_write = 1'b1;
      o.reg_dst   = 1'b1;
      o.alu_ctrl  = alu;
      return o;
   endfunction

   function automatic out_t o_memadr();
      out_t o;
      o = o_base();
      o.alu_src_a = 1'b1;
      o.alu_src_b = 2'd2;
      return o;
   endfunction

   function automatic out_t o_memrd(input logic tmo);
      out_t o;
      o = o_base();
      o.mem_read = ~tmo;
      o.iord     = 1'b1;
      o.mem_err  = tmo;
      return o;
   endfunction

   function automatic out_t o_memwb();
      out_t o;
      o = o_base();
      o.reg_write  = 1'b1;
      o.mem_to_reg = 1'b1;
      return o;
   endfunction

   function automatic out_t o_memwr(input logic tmo);
      out_t o;
      o = o_base();
      o.mem_write = ~tmo;
      o.iord      = 1'b1;
      o.mem_err   = tmo;
      return o;
   endfunction

   function automatic out_t o_exec_i(input logic ori);
      out_t o;
      o = o_base();
      o.alu_src_a = 1'b1;
      o.alu_src_b = 2'd2;
      o.ext_zero  = ori;
      o.alu_ctrl  = ori ? ALU_OR : ALU_ADD;
      return o;
   endfunction

   function automatic out_t o_iwb(input logic ori);
      out_t o;
      o = o_base();
      o.reg_write = 1'b1;
      o.alu_ctrl  = ori ? ALU_OR : ALU_ADD;
      return o;
   endfunction

   function automatic out_t o_branch();
      out_t o;
      o = o_base();
      o.alu_src_a     = 1'b1;
      o.alu_ctrl      = ALU_SUB;
      o.pc_write_cond = 1'b1;
      o.pc_source     = 2'd1;
      return o;
   endfunction

   function automatic out_t o_jump();
      out_t o;
      o = o_base();
      o.pc_write  = 1'b1;
      o.pc_source = 2'd2;
      return o;
   endfunction

   function automatic cyc_t mk(input logic [5:0] opc, input logic [5:0] fn,
                               input logic z, input logic rdy, input out_t e,
                               input bit ret);
      cyc_t c;
      c.opc = opc; c.fn = fn; c.z = z; c.rdy = rdy; c.exp = e; c.ret = ret;
      return c;
   endfunction

   function automatic out_t sample();
      out_t o;
      o.pc_write      = pc_write;
      o.pc_write_cond = pc_write_cond;
      o.iord          = iord;
      o.mem_read      = mem_read;
      o.mem_write     = mem_write;
      o.ir_write      = ir_write;
      o.mem_to_reg    = mem_to_reg;
      o.reg_dst       = reg_dst;
      o.reg_write     = reg_write;
      o.alu_src_a     = alu_src_a;
      o.alu_src_b     = alu_src_b;
      o.ext_zero      = ext_zero;
      o.pc_source     = pc_source;
      o.alu_ctrl      = alu_ctrl;
      o.illegal       = illegal;
      o.mem_err       = mem_err;
      return o;
   endfunction

   // Apply one cycle of inputs, queue its expectation, move to the sample point.
   task automatic drive(input cyc_t c);
      opcode    = c.opc;
      funct     = c.fn;
      zero      = c.z;
      mem_ready = c.rdy;
      sb_q.push_back(c.exp);
      @(negedge clk);
   endtask

   task automatic advance(input bit ret);
      @(posedge clk);
      if (ret) exp_inst = exp_inst + 32'(INC);
      #1;
   endtask

   task automatic test_reset();
      out_t got, exp;
      rst_n = 1'b0; opcode = OP_BAD; funct = 6'h00; zero = 1'b1; mem_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         sb_q.push_back(o_base());
         @(negedge clk);
         exp = sb_q.pop_front();
         got = sample();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL reset cyc%0d outputs got=%h want=%h", i, got, exp);
         end
         checks++;
         if (inst_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset cyc%0d inst_cnt got=%0d want=0", i, inst_cnt);
         end
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_rtype();
      cyc_t cs[$];
      out_t got, exp;
      logic [5:0] fns [5];
      logic [2:0] alus[5];
      fns  = '{6'h25, 6'h20, 6'h22, 6'h24, 6'h2A};
      alus = '{ALU_OR, ALU_ADD, ALU_SUB, ALU_AND, ALU_SLT};
      for (int k = 0; k < 5; k++) begin
         cs.push_back(mk(OP_R, fns[k], 1'b0, 1'b1, o_fetch(1'b1, 1'b0), 1'b0));
         cs.push_back(mk(OP_R, fns[k], 1'b0, 1'b1, o_decode(1'b0), 1'b0));
         cs.push_back(mk(OP_R, fns[k], 1'b0, 1'b1, o_exec_r(alus[k]), 1'b0));
         cs.push_back(mk(OP_R, fns[k], 1'b0, 1'b1, o_rwb(alus[k]), 1'b1));
      end
      foreach (cs[i]) begin
         drive(cs[i]);
         exp = sb_q.pop_front();
         got = sample();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL rtype cyc%0d outputs got=%h want=%h", i, got, exp);
         end
         checks++;
         if (inst_cnt !== exp_inst) begin
            failures++;
            $display("FAIL rtype cyc%0d inst_cnt got=%0d want=%0d", i, inst_cnt, exp_inst);
         end
         advance(cs[i].ret);
      end
   endtask

   task automatic test_lw_wait();
      cyc_t cs[$];
      out_t got, exp;
      cs.push_back(mk(OP_LW, 6'h00, 1'b0, 1'b1, o_fetch(1'b1, 1'b0), 1'b0));
      cs.push_back(mk(OP_LW, 6'h00, 1'b0, 1'b0, o_decode(1'b0), 1'b0));
      cs.push_back(mk(OP_LW, 6'h00, 1'b0, 1'b0, o_memadr(), 1'b0));
      for (int k = 0; k < 3; k++)
         cs.push_back(mk(OP_LW, 6'h00, 1'b0, 1'b0, o_memrd(1'b0), 1'b0));
      cs.push_back(mk(OP_LW, 6'h00, 1'b0, 1'b1, o_memrd(1'b0), 1'b0));
      cs.push_back(mk(OP_LW, 6'h00, 1'b0, 1'b0, o_memwb(), 1'b1));
      foreach (cs[i]) begin
         drive(cs[i]);
         exp = sb_q.pop_front();
         got = sample();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL lw_wait cyc%0d outputs got=%h want=%h", i, got, exp);
         end
         checks++;
         if (inst_cnt !== exp_inst) begin
            failures++;
            $display("FAIL lw_wait cyc%0d inst_cnt got=%0d want=%0d", i, inst_cnt, exp_inst);
         end
         advance(cs[i].ret);
      end
   endtask

   task automatic test_beq();
      cyc_t cs[$];
      out_t got, exp;
      for (int k = 0; k < 2; k++) begin
         cs.push_back(mk(OP_BEQ, 6'h00, 1'(k == 0), 1'b1, o_fetch(1'b1, 1'b0), 1'b0));
         cs.push_back(mk(OP_BEQ, 6'h00, 1'(k == 0), 1'b1, o_decode(1'b0), 1'b0));
         cs.push_back(mk(OP_BEQ, 6'h00, 1'(k == 0), 1'b1, o_branch(), 1'b1));
      end
      foreach (cs[i]) begin
         drive(cs[i]);
         exp = sb_q.pop_front();
         got = sample();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL beq cyc%0d outputs got=%h want=%h", i, got, exp);
         end
         checks++;
         if (inst_cnt !== exp_inst) begin
            failures++;
            $display("FAIL beq cyc%0d inst_cnt got=%0d want=%0d", i, inst_cnt, exp_inst);
         end
         advance(cs[i].ret);
      end
   endtask

   task automatic test_illegal();
      cyc_t cs[$];
      out_t got, exp;
      cs.push_back(mk(OP_BAD, 6'h20, 1'b0, 1'b1, o_fetch(1'b1, 1'b0), 1'b0));
      cs.push_back(mk(OP_BAD, 6'h20, 1'b0, 1'b1, o_decode(1'b1), 1'b0));
      cs.push_back(mk(OP_R,   6'h00, 1'b0, 1'b1, o_fetch(1'b1, 1'b0), 1'b0));
      cs.push_back(mk(OP_R,   6'h00, 1'b0, 1'b1, o_decode(1'b1), 1'b0));
      foreach (cs[i]) begin
         drive(cs[i]);
         exp = sb_q.pop_front();
         got = sample();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL illegal cyc%0d outputs got=%h want=%h", i, got, exp);
         end
         checks++;
         if (inst_cnt !== exp_inst) begin
            failures++;
            $display("FAIL illegal cyc%0d inst_cnt got=%0d want=%0d", i, inst_cnt, exp_inst);
         end
         advance(cs[i].ret);
      end
   endtask

   task automatic test_back_to_back();
      cyc_t cs[$];
      out_t got, exp;
      for (int k = 0; k < 2; k++) begin
         cs.push_back(mk(k ? OP_ORI : OP_ADDI, 6'h00, 1'b0, 1'b1, o_fetch(1'b1, 1'b0), 1'b0));
         cs.push_back(mk(k ? OP_ORI : OP_ADDI, 6'h00, 1'b0, 1'b1, o_decode(1'b0), 1'b0));
         cs.push_back(mk(k ? OP_ORI : OP_ADDI, 6'h00, 1'b0, 1'b1, o_exec_i(1'(k)), 1'b0));
         cs.push_back(mk(k ? OP_ORI : OP_ADDI, 6'h00, 1'b0, 1'b1, o_iwb(1'(k)), 1'b1));
      end
      cs.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b1, o_fetch(1'b1, 1'b0), 1'b0));
      cs.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b1, o_decode(1'b0), 1'b0));
      cs.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b1, o_memadr(), 1'b0));
      cs.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b1, o_memwr(1'b0), 1'b1));
      cs.push_back(mk(OP_J,  6'h00, 1'b0, 1'b1, o_fetch(1'b1, 1'b0), 1'b0));
      cs.push_back(mk(OP_J,  6'h00, 1'b0, 1'b1, o_decode(1'b0), 1'b0));
      cs.push_back(mk(OP_J,  6'h00, 1'b0, 1'b1, o_jump(), 1'b1));
      foreach (cs[i]) begin
         drive(cs[i]);
         exp = sb_q.pop_front();
         got = sample();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL back_to_back cyc%0d outputs got=%h want=%h", i, got, exp);
         end
         checks++;
         if (inst_cnt !== exp_inst) begin
            failures++;
            $display("FAIL back_to_back cyc%0d inst_cnt got=%0d want=%0d", i, inst_cnt, exp_inst);
         end
         advance(cs[i].ret);
      end
   endtask

   task automatic test_timeout();
      cyc_t cs[$];
      out_t got, exp;
      // Fetch stuck: counter 0..3 waits, expiry at 4, then a fresh fetch.
      for (int k = 0; k < 4; k++)
         cs.push_back(mk(OP_J, 6'h00, 1'b0, 1'b0, o_fetch(1'b0, 1'b0), 1'b0));
      cs.push_back(mk(OP_J, 6'h00, 1'b0, 1'b0, o_fetch(1'b0, 1'b1), 1'b0));
      for (int k = 0; k < 3; k++)
         cs.push_back(mk(OP_J, 6'h00, 1'b0, 1'b0, o_fetch(1'b0, 1'b0), 1'b0));
      cs.push_back(mk(OP_J, 6'h00, 1'b0, 1'b1, o_fetch(1'b1, 1'b0), 1'b0));
      cs.push_back(mk(OP_J, 6'h00, 1'b0, 1'b1, o_decode(1'b0), 1'b0));
      cs.push_back(mk(OP_J, 6'h00, 1'b0, 1'b1, o_jump(), 1'b1));
      // Store stuck: aborted without retiring.
      cs.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b1, o_fetch(1'b1, 1'b0), 1'b0));
      cs.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b0, o_decode(1'b0), 1'b0));
      cs.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b0, o_memadr(), 1'b0));
      for (int k = 0; k < 4; k++)
         cs.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b0, o_memwr(1'b0), 1'b0));
      cs.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b0, o_memwr(1'b1), 1'b0));
      // Load ready exactly at the limit: normal completion.
      cs.push_back(mk(OP_LW, 6'h00, 1'b0, 1'b1, o_fetch(1'b1, 1'b0), 1'b0));
      cs.push_back(mk(OP_LW, 6'h00, 1'b0, 1'b0, o_decode(1'b0), 1'b0));
      cs.push_back(mk(OP_LW, 6'h00, 1'b0, 1'b0, o_memadr(), 1'b0));
      for (int k = 0; k < 4; k++)
         cs.push_back(mk(OP_LW, 6'h00, 1'b0, 1'b0, o_memrd(1'b0), 1'b0));
      cs.push_back(mk(OP_LW, 6'h00, 1'b0, 1'b1, o_memrd(1'b0), 1'b0));
      cs.push_back(mk(OP_LW, 6'h00, 1'b0, 1'b0, o_memwb(), 1'b1));
      foreach (cs[i]) begin
         drive(cs[i]);
         exp = sb_q.pop_front();
         got = sample();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL timeout cyc%0d outputs got=%h want=%h", i, got, exp);
         end
         checks++;
         if (inst_cnt !== exp_inst) begin
            failures++;
            $display("FAIL timeout cyc%0d inst_cnt got=%0d want=%0d", i, inst_cnt, exp_inst);
         end
         advance(cs[i].ret);
      end
   endtask

   task automatic test_async_reset();
      cyc_t cs[$];
      out_t got, exp;
      cs.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b1, o_fetch(1'b1, 1'b0), 1'b0));
      cs.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b0, o_decode(1'b0), 1'b0));
      cs.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b0, o_memadr(), 1'b0));
      cs.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b0, o_memwr(1'b0), 1'b0));
      foreach (cs[i]) begin
         drive(cs[i]);
         exp = sb_q.pop_front();
         got = sample();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL async_rst cyc%0d outputs got=%h want=%h", i, got, exp);
         end
         if (i < cs.size() - 1) advance(cs[i].ret);
      end
      // Mid-MEM_WR, between edges: outputs must go idle without a clock.
      #2;
      rst_n = 1'b0;
      exp_inst = 32'd0;
      sb_q.push_back(o_base());
      #1;
      exp = sb_q.pop_front();
      got = sample();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL async_rst asserted outputs got=%h want=%h", got, exp);
      end
      checks++;
      if (inst_cnt !== exp_inst) begin
         failures++;
         $display("FAIL async_rst asserted inst_cnt got=%0d want=0", inst_cnt);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(mk(OP_SW, 6'h00, 1'b0, 1'b1, o_fetch(1'b1, 1'b0), 1'b0));
      exp = sb_q.pop_front();
      got = sample();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL async_rst first_fetch outputs got=%h want=%h", got, exp);
      end
      checks++;
      if (inst_cnt !== exp_inst) begin
         failures++;
         $display("FAIL async_rst first_fetch inst_cnt got=%0d want=0", inst_cnt);
      end
      advance(1'b0);
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_lw_wait();
      test_beq();
      test_illegal();
      test_back_to_back();
      test_timeout();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Main control FSM for the multi-cycle 32-bit CPU.
- Sequences fetch/decode/execute/memory/writeback over the shared datapath: one ALU (add/sub/and/or/slt bit-slices), single memory port, IR, register file, PC.
- Drives every datapath strobe and mux select, plus the ALU function code.
- Handshakes with memory through mem_ready and bounds each memory wait with a timeout.

Parameters:
- TIMEOUT_CYC, 255, max cycles a memory state waits for mem_ready before abort (1..2^CNT_W-1).
- CNT_W, 8, width of the wait counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero=1
- iord  out  1  0=PC addresses memory, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- mem_to_reg  out  1  register-file write data: 0=ALUOut, 1=MDR
- reg_dst  out  1  write register: 0=rt, 1=rd
- reg_write  out  1  register-file write
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
- ext_zero  out  1  immediate zero-extended (ori)
- pc_source  out  2  0=ALU result, 1=ALUOut, 2=jump target
- alu_ctrl  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- illegal  out  1  one-cycle pulse on unsupported opcode/funct
- mem_err  out  1  one-cycle pulse on memory timeout
- inst_cnt  out  32  retired-instruction count (optional feature)

Behaviour:
- Reset: state=FETCH, wait counter=0. All outputs 0 while rst_n=0, including requests and pulses; alu_ctrl=010 for the same period. First fetch begins on the first edge after release.
- States: FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP.
- Outputs are combinational from state, plus opcode/funct/mem_ready where noted. Every strobe not listed for a state is 0.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, ADD, pc_source=0.
  - ir_write and pc_write=1 only in the cycle mem_ready=1; that cycle goes to DECODE. Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=3, ADD (branch target into ALUOut). Next state by opcode:
  - 0x00 R-type -> EXEC_R, after funct check.
  - 0x23 lw or 0x2B sw -> MEM_ADR.
  - 0x08 addi or 0x0D ori -> EXEC_I.
  - 0x04 beq -> BRANCH.
  - 0x02 j -> JUMP.
  - Other opcode -> illegal=1, next FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=0. alu_ctrl from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT. Unknown funct is caught in DECODE (illegal=1, next FETCH). Next R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, alu_ctrl held from funct. Next FETCH.
- MEM_ADR: alu_src_a=1, alu_src_b=2, ADD. Next MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read=1, iord=1. On mem_ready -> MEM_WB; otherwise wait.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Next FETCH.
- MEM_WR: mem_write=1, iord=1. On mem_ready -> FETCH; otherwise wait.
- EXEC_I: alu_src_a=1, alu_src_b=2, ADD for addi. For ori: OR with ext_zero=1. Next I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, alu_ctrl as in EXEC_I. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_write_cond=1, pc_source=1. Next FETCH.
- JUMP: pc_write=1, pc_source=2. Next FETCH.
- Timeout:
  - Wait counter clears on entering FETCH/MEM_RD/MEM_WR and increments each cycle mem_ready=0.
  - When the counter equals TIMEOUT_CYC with mem_ready still 0: mem_err=1 for one cycle, requests drop, next FETCH. Nothing is written; PC is not updated.
  - mem_ready=1 in that same cycle wins; it is a normal completion.
- Async reset mid-instruction aborts immediately; no partial writeback is completed.

Optional Feature:
- Macro MULTI_CYCLE_CTRL_INST_CNT_EN.
- Defined:
  - inst_cnt is a 32-bit counter, reset 0.
  - Increments by 1 on every transition into FETCH from R_WB, MEM_WB, MEM_WR (completed), I_WB, BRANCH or JUMP.
  - Illegal and timeout aborts do not count. Wraps 0xFFFFFFFF -> 0.
- Undefined: inst_cnt tied to 0, no counter flops.

Test Plan:
- Reset, then mem_ready=1 always, instruction R-type or (funct 0x25): states FETCH->DECODE->EXEC_R->R_WB->FETCH. alu_ctrl=001 in EXEC_R; reg_write=1 and reg_dst=1 in R_WB; 4 cycles per instruction.
- lw with mem_ready delayed 3 cycles in MEM_RD: mem_read and iord held 3 cycles. MEM_WB follows the ready cycle with reg_write=1 and mem_to_reg=1. Total 5+3 cycles.
- beq in BRANCH with zero=1, then zero=0: pc_write_cond=1 and pc_source=1 in both cases. alu_ctrl=110. Next state FETCH.
- Opcode 0x3F, then R-type with funct 0x00: illegal pulses exactly 1 cycle, no reg_write. Returns to FETCH; inst_cnt unchanged.
- TIMEOUT_CYC=4, mem_ready stuck 0 in FETCH: mem_err pulses when the counter reaches 4. ir_write and pc_write never asserted. Returns to FETCH. Then mem_ready=1 completes normally.
- rst_n asserted low mid-MEM_WR: all outputs 0 within the same cycle, asynchronously. After release, first state is FETCH and inst_cnt=0.
